// File: rtl/square_wave_meter.sv
// Square-wave monitor: synchronizes an asynchronous toggling input and reports
// high time, low time and period in clk cycles, with a per-period valid strobe.
module square_wave_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned PER_W  = CNT_W + 1;
    localparam int unsigned FILL_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_primed;
    logic [FILL_W-1:0]      r_fill;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi;
    logic [CNT_W-1:0]       r_high;
    logic [CNT_W-1:0]       r_low;
    logic [PER_W-1:0]       r_per;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_to;

    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_hi_nxt;
    logic [CNT_W-1:0]       w_high_nxt;
    logic [CNT_W-1:0]       w_low_nxt;
    logic [PER_W-1:0]       w_per_nxt;
    logic                   w_valid_nxt;
    logic                   w_locked_nxt;
    logic                   w_to_nxt;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;
    logic                   w_sat;

    // Synchronizer plus priming; priming waits until the chain holds a real
    // post-reset sample so a level present at reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_prev   <= 1'b0;
            r_primed <= 1'b0;
            r_fill   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= w_s;
            if (!r_primed) begin
                r_fill <= r_fill + FILL_W'(1);
                if (r_fill == FILL_W'(SYNC_STAGES)) begin
                    r_primed <= 1'b1;
                end
            end
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = r_primed &  w_s & ~r_prev;
    assign w_fall = r_primed & ~w_s &  r_prev;
    assign w_edge = w_rise | w_fall;
    assign w_sat  = (r_state != ST_IDLE) && (r_cnt == CNT_MAX) && !w_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_rise) w_state_nxt = ST_HIGH;
            ST_HIGH: begin
                if (w_fall)     w_state_nxt = ST_LOW;
                else if (w_sat) w_state_nxt = ST_IDLE;
            end
            ST_LOW: begin
                if (w_rise)     w_state_nxt = ST_HIGH;
                else if (w_sat) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the level counter and the registered measurement outputs.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_high_nxt   = r_high;
        w_low_nxt    = r_low;
        w_per_nxt    = r_per;
        w_valid_nxt  = 1'b0;
        w_locked_nxt = r_locked;
        w_to_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = w_rise ? CNT_W'(1) : '0;
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_hi_nxt  = r_cnt;
                    w_cnt_nxt = CNT_W'(1);
                end else if (w_sat) begin
                    w_to_nxt     = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_high_nxt   = r_hi;
                    w_low_nxt    = r_cnt;
                    w_per_nxt    = PER_W'(r_hi) + PER_W'(r_cnt);
                    w_valid_nxt  = 1'b1;
                    w_locked_nxt = 1'b1;
                    w_cnt_nxt    = CNT_W'(1);
                end else if (w_sat) begin
                    w_to_nxt     = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_high   <= '0;
            r_low    <= '0;
            r_per    <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_high   <= w_high_nxt;
            r_low    <= w_low_nxt;
            r_per    <= w_per_nxt;
            r_valid  <= w_valid_nxt;
            r_locked <= w_locked_nxt;
            r_to     <= w_to_nxt;
        end
    end

    assign meas_valid = r_valid;
    assign high_cnt   = r_high;
    assign low_cnt    = r_low;
    assign period_cnt = r_per;
    assign locked     = r_locked;
    assign timeout    = r_to;

endmodule

// File: tb/tb_square_wave_meter.sv
// Bench for square_wave_meter: two instances (CNT_W=16 and CNT_W=4) share one
// stimulus; expected events come from a level-list model of the measurement rules.
module tb_square_wave_meter;

    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;
    localparam int LAT   = 3;

    typedef struct {
        int kind;
        int cyc;
        int hi;
        int lo;
        int per;
        int lck;
    } ev_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        sig_in = 1'b0;

    logic        a_valid, a_locked, a_to;
    logic [15:0] a_high, a_low;
    logic [16:0] a_per;
    logic        b_valid, b_locked, b_to;
    logic [3:0]  b_high, b_low;
    logic [4:0]  b_per;

    int cyc       = 0;
    int n_vec     = 0;
    int n_err     = 0;
    int rst_noise = 0;
    bit seg_on    = 1'b0;

    ev_t obs_a[$];
    ev_t obs_b[$];
    ev_t exp_q[$];
    int  lv_val[$];
    int  lv_start[$];
    int  lv_dur[$];

    square_wave_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .meas_valid(a_valid), .high_cnt(a_high), .low_cnt(a_low),
        .period_cnt(a_per), .locked(a_locked), .timeout(a_to)
    );

    square_wave_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .meas_valid(b_valid), .high_cnt(b_high), .low_cnt(b_low),
        .period_cnt(b_per), .locked(b_locked), .timeout(b_to)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe with the values and cycle it appeared on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid) obs_a.push_back('{0, cyc, int'(a_high), int'(a_low), int'(a_per), int'(a_locked)});
            if (a_to)    obs_a.push_back('{1, cyc, int'(a_high), int'(a_low), int'(a_per), int'(a_locked)});
            if (b_valid) obs_b.push_back('{0, cyc, int'(b_high), int'(b_low), int'(b_per), int'(b_locked)});
            if (b_to)    obs_b.push_back('{1, cyc, int'(b_high), int'(b_low), int'(b_per), int'(b_locked)});
        end else if (a_valid || a_to || b_valid || b_to) begin
            rst_noise++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int k, input int c, input int h, input int l, input int lk, input int endc);
        if (c <= endc) exp_q.push_back('{k, c, h, l, h + l, lk});
    endtask

    // Walk the applied levels: a rise starts tracking, a completed high+low pair
    // is reported at the next rise, any level longer than max times out.
    task automatic build(input int max, input int endc);
        int tracking, pend, hi, lo, lhi, llo, v, d, st;
        exp_q.delete();
        tracking = 0; pend = 0; hi = 0; lo = 0; lhi = 0; llo = 0;
        for (int i = 1; i < lv_val.size(); i++) begin
            v  = lv_val[i];
            st = lv_start[i];
            d  = (i == lv_val.size() - 1) ? (1 << 30) : lv_dur[i];
            if (v == 1) begin
                if (tracking != 0 && pend != 0) begin
                    lhi = hi; llo = lo;
                    push_exp(0, st + LAT, hi, lo, 1, endc);
                end
                pend = 0; tracking = 1;
                if (d > max) begin
                    push_exp(1, st + LAT + max, lhi, llo, 0, endc);
                    tracking = 0;
                end else begin
                    hi = d;
                end
            end else if (tracking != 0) begin
                if (d > max) begin
                    push_exp(1, st + LAT + max, lhi, llo, 0, endc);
                    tracking = 0;
                end else begin
                    lo = d; pend = 1;
                end
            end
        end
    endtask

    task automatic cmp_inst(input string nm, input int sel, input int max, input int endc);
        ev_t o[$];
        int  n;
        build(max, endc);
        o = (sel != 0) ? obs_b : obs_a;
        check_eq({nm, "_event_count"}, o.size(), exp_q.size());
        n = (o.size() < exp_q.size()) ? o.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq({nm, "_kind"},   o[i].kind, exp_q[i].kind);
            check_eq({nm, "_cycle"},  o[i].cyc,  exp_q[i].cyc);
            check_eq({nm, "_high"},   o[i].hi,   exp_q[i].hi);
            check_eq({nm, "_low"},    o[i].lo,   exp_q[i].lo);
            check_eq({nm, "_period"}, o[i].per,  exp_q[i].per);
            check_eq({nm, "_locked"}, o[i].lck,  exp_q[i].lck);
        end
    endtask

    task automatic drive(input int v, input int d);
        sig_in = v[0];
        lv_val.push_back(v);
        lv_start.push_back(cyc);
        lv_dur.push_back(d);
        repeat (d) @(negedge clk);
    endtask

    // Close the current segment, assert reset mid-cycle, start a new segment at level v0.
    task automatic do_reset(input int v0, input int tog);
        int endc;
        @(negedge clk);
        #2;
        endc  = cyc;
        rst_n = 1'b0;
        if (seg_on) begin
            cmp_inst("A", 0, MAX_A, endc);
            cmp_inst("B", 1, MAX_B, endc);
        end
        #1;
        check_eq("rst_a_valid",  a_valid,  0);
        check_eq("rst_a_high",   a_high,   0);
        check_eq("rst_a_low",    a_low,    0);
        check_eq("rst_a_period", a_per,    0);
        check_eq("rst_a_locked", a_locked, 0);
        check_eq("rst_a_tmo",    a_to,     0);
        check_eq("rst_b_locked", b_locked, 0);
        check_eq("rst_b_period", b_per,    0);
        repeat (tog) begin
            @(negedge clk);
            sig_in = ~sig_in;
        end
        @(negedge clk);
        sig_in = v0[0];
        obs_a.delete(); obs_b.delete();
        lv_val.delete(); lv_start.delete(); lv_dur.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        seg_on = 1'b1;
        lv_val.push_back(v0);
        lv_start.push_back(cyc);
        lv_dur.push_back(0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset(0, 5);

        // symmetric 3/3 square wave
        for (int i = 0; i < 10; i++) begin drive(1, 3); drive(0, 3); end
        do_reset(0, 2);

        // asymmetric 5/2
        for (int i = 0; i < 6; i++) begin drive(1, 5); drive(0, 2); end
        do_reset(1, 3);

        // input high across reset release
        drive(0, 4);
        for (int i = 0; i < 4; i++) begin drive(1, 4); drive(0, 6); end
        do_reset(0, 0);

        // saturation boundaries for the narrow instance, then recovery
        drive(1, 4);  drive(0, 3);
        drive(1, 15); drive(0, 2);
        drive(1, 16); drive(0, 3);
        drive(1, 2);  drive(0, 16);
        drive(1, 3);  drive(0, 3);
        drive(1, 3);  drive(0, 40);
        do_reset(0, 1);

        // random levels, including 1-cycle pulses
        for (int i = 0; i < 40; i++) begin
            drive(1, int'($urandom_range(1, 20)));
            drive(0, int'($urandom_range(1, 20)));
        end
        // full-scale high level on the wide instance: edge wins at max count
        drive(1, MAX_A); drive(0, 7);
        drive(1, 2);     drive(0, 3);
        drive(1, 4);     drive(0, 2);
        // reset lands in the middle of a low level
        do_reset(0, 0);

        for (int i = 0; i < 5; i++) begin drive(1, 3); drive(0, 3); end
        drive(1, 3);
        do_reset(0, 0);

        check_eq("quiet_during_reset", rst_noise, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
